// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared widths and FSM encoding for the wavetable scanner
package wave_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 20;
    localparam int PHASE_W = 24;
    localparam int FRAC_W  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_A = 3'd1,
        ADDR_B = 3'd2,
        INTERP = 3'd3,
        VALID  = 3'd4
    } state_t;

endpackage

// File: rtl/wave_scanner_if.sv
// rtl/wave_scanner_if.sv - sample output stream with valid/ready handshake
interface wave_scanner_if #(
    parameter int DATA_W = 20
) ();

    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_out,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_out,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/wave_lerp.sv
// rtl/wave_lerp.sv - linear interpolation between two adjacent wavetable words
module wave_lerp
    import wave_pkg::*;
#(
    parameter int DW = 20,
    parameter int FW = FRAC_W
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic        [FW-1:0] f,
    output logic signed [DW-1:0] y
);

    localparam int PW = DW + FW + 1;

    logic signed [DW:0]   diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    assign diff    = $signed({b[DW-1], b}) - $signed({a[DW-1], a});
    assign prod    = $signed({{FW{diff[DW]}}, diff}) * $signed({{(DW + 1){1'b0}}, f});
    assign shifted = prod >>> FW;
    // Result always lies between a and b, so wrapping to DW bits is exact.
    assign y       = DW'(PW'(a) + shifted);

endmodule

// File: rtl/wave_scanner.sv
// rtl/wave_scanner.sv - phase-accumulating wavetable scanner with interpolated output
module wave_scanner
    import wave_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int DATA_W  = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               sample_tick,
    input  logic               sync_in,
    input  logic [PHASE_W-1:0] tune,
    output logic [ADDR_W-1:0]  ram_sel,
    input  logic [DATA_W-1:0]  ram_data,
    wave_scanner_if.master     sif,
    output logic               busy,
    output logic               overrun
);

    state_t                    state;
    logic [PHASE_W-1:0]        phase;
    logic [PHASE_W-1:0]        phase_use;
    logic [ADDR_W-1:0]         idx;
    logic [FRAC_W-1:0]         frac;
    logic signed [DATA_W-1:0]  a_q;
    logic signed [DATA_W-1:0]  b_q;
    logic signed [DATA_W-1:0]  lerp_y;
    logic                      tick_ok;

    assign tick_ok   = enable & sample_tick;
    // Hard sync coinciding with a tick makes that sample start from phase 0.
    assign phase_use = sync_in ? '0 : phase;

    wave_lerp #(
        .DW (DATA_W),
        .FW (FRAC_W)
    ) u_lerp (
        .a (a_q),
        .b (b_q),
        .f (frac),
        .y (lerp_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            phase            <= '0;
            idx              <= '0;
            frac             <= '0;
            a_q              <= '0;
            b_q              <= '0;
            ram_sel          <= '0;
            sif.sample_out   <= '0;
            sif.sample_valid <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            overrun <= tick_ok && (state != IDLE);
            if (sync_in) begin
                phase <= '0;
            end
            case (state)
                IDLE: begin
                    if (tick_ok) begin
                        phase   <= phase_use + tune;
                        idx     <= phase_use[PHASE_W-1 -: ADDR_W];
                        frac    <= phase_use[PHASE_W-ADDR_W-1 -: FRAC_W];
                        ram_sel <= phase_use[PHASE_W-1 -: ADDR_W];
                        busy    <= 1'b1;
                        state   <= ADDR_A;
                    end
                end
                ADDR_A: begin
                    a_q     <= ram_data;
                    ram_sel <= idx + ADDR_W'(1);
                    state   <= ADDR_B;
                end
                ADDR_B: begin
                    b_q   <= ram_data;
                    state <= INTERP;
                end
                INTERP: begin
                    sif.sample_out   <= lerp_y;
                    sif.sample_valid <= 1'b1;
                    state            <= VALID;
                end
                VALID: begin
                    if (sif.sample_ready) begin
                        sif.sample_valid <= 1'b0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    sif.sample_valid <= 1'b0;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wave_scanner.md
WAVE_SCANNER -- requirements
Module: wave_scanner

Interface
REQ-001 Parameter PHASE_W, default 24: phase accumulator width; top 6 bits form the table index, the next 8 bits form the interpolation fraction.
REQ-002 Parameter DATA_W, default 20: signed two's-complement sample width; matches the 64-entry wavetable RAM word.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 enable  in  1  1 = scanner runs; 0 = ticks ignored, phase held.
REQ-006 sample_tick  in  1  one-cycle pulse requesting the next output sample.
REQ-007 sync_in  in  1  one-cycle pulse that zeroes the phase accumulator (oscillator hard sync).
REQ-008 tune  in  PHASE_W  unsigned phase increment added once per accepted tick.
REQ-009 ram_sel  out  6  registered read address to the wavetable RAM.
REQ-010 ram_data  in  DATA_W  RAM read word; combinational function of ram_sel, valid in the same cycle.
REQ-011 sample_out  out  DATA_W  interpolated signed sample.
REQ-012 sample_valid  out  1  sample_out holds a new sample.
REQ-013 sample_ready  in  1  downstream accepts sample_out when sample_valid and sample_ready are both 1.
REQ-014 busy  out  1  1 in every state other than IDLE.
REQ-015 overrun  out  1  one-cycle pulse when a tick is dropped.

Function
REQ-016 FSM states SHALL be IDLE, ADDR_A, ADDR_B, INTERP and VALID, advancing one state per cycle except in IDLE and VALID.
REQ-017 IDLE: when enable=1 and sample_tick=1, latch phase, set ram_sel = phase[PHASE_W-1 -: 6], and go to ADDR_A.
REQ-018 ADDR_A: capture ram_data as A, set ram_sel = (index+1) mod 64 (63 wraps to 0), and go to ADDR_B.
REQ-019 ADDR_B: capture ram_data as B, and go to INTERP.
REQ-020 INTERP: register sample_out = A + (((B - A) * f) >>> 8), where f = unsigned 8-bit fraction, B - A is a 21-bit signed value, the product is 29-bit signed, and >>> is an arithmetic shift; go to VALID.
REQ-021 The INTERP result SHALL always lie between A and B inclusive, so no saturation is required.
REQ-022 VALID: assert sample_valid; on sample_valid and sample_ready, deassert it and go to IDLE.
REQ-023 While in VALID, sample_out SHALL stay stable.
REQ-024 Latency: a tick accepted at cycle T SHALL give sample_valid=1 at cycle T+4.
REQ-025 Phase SHALL update to phase + tune, modulo 2^PHASE_W, in the cycle the tick is accepted; the sample SHALL use the pre-increment phase.
REQ-026 sync_in SHALL set phase to 0 in any state.
REQ-027 If sync_in and an accepted tick occur in the same cycle, the sample SHALL use phase 0 and phase SHALL become tune.
REQ-028 A sample_tick arriving while not in IDLE and with enable=1 SHALL be dropped and SHALL pulse overrun for one cycle.
REQ-029 With enable=0, ticks SHALL be ignored and overrun SHALL NOT pulse.
REQ-030 Deasserting enable mid-sequence SHALL NOT abort the sequence; the sample completes.
REQ-031 The block SHALL never write the RAM; the RAM LOAD input is owned by the loader.

Reset
REQ-032 On rst_n=0, outputs SHALL immediately take: state IDLE, phase 0, ram_sel 0, sample_out 0, sample_valid 0, busy 0, overrun 0, A and B 0.
REQ-033 Reset mid-sequence SHALL discard the pending sample; no sample_valid SHALL appear after release until a new tick.

Structure
REQ-034 Package wave_pkg SHALL hold ADDR_W=6, DATA_W, PHASE_W, FRAC_W=8, and the FSM state encoding.
REQ-035 Interpolation arithmetic SHALL live in sub-module wave_lerp (pure combinational: A, B, f in; result out).

Verification (RAM preloaded with entry i = i*1000; entry 63 = 63000)
REQ-036 Bench SHALL cover: tune=0x040000, 3 ticks -> ram_sel sequence 0,1 / 1,2 / 2,3; samples 0, 1000, 2000, each valid 4 cycles after its tick.
REQ-037 Bench SHALL cover: tune=0x020000, 2 ticks -> samples 0 and 500.
REQ-038 Bench SHALL cover: phase preset via sync and 0xFE0000 ticks, reaching phase 0xFE0000 -> ram_sel 63 then 0; sample 31500.
REQ-039 Bench SHALL cover: second tick 2 cycles after the first -> overrun pulses once; exactly one sample_valid.
REQ-040 Bench SHALL cover: sample_ready=0 for 10 cycles -> sample_valid held and sample_out stable; a tick during the hold -> overrun.
REQ-041 Bench SHALL cover: rst_n low during ADDR_B -> all outputs 0 immediately; no sample_valid after release; sync_in plus tick together -> sample 0.
